// File: rtl/masked_sbox_pkg.sv
// Shared constants and helpers for the masked tower-field S-box datapath.
// Factor-vector bit positions are exported for the downstream masked multipliers.
package masked_sbox_pkg;

    localparam int W_GF16 = 4;
    localparam int W_GF4  = 2;

    // Factor-vector bit positions (W=4 layout; Q_AL is also bit 2 for W=2)
    localparam int Q_AA    = 8;
    localparam int Q_SA_HI = 7;
    localparam int Q_SA_LO = 6;
    localparam int Q_AH    = 5;
    localparam int Q_AL    = 2;

    function automatic int qw_of(input int w);
        return (w == W_GF16) ? 9 : 3;
    endfunction

endpackage

// File: rtl/fac_expand.sv
// Single-share factor-sum expander, purely combinational and linear in a_i,
// so it can be applied share-wise without ever combining shares.
module fac_expand
    import masked_sbox_pkg::*;
#(
    parameter  int W  = 4,
    localparam int QW = qw_of(W)
) (
    input  logic [W-1:0]  a_i,
    output logic [QW-1:0] q_o
);

    if (W == W_GF16) begin : g_w4
        logic [1:0] sa;
        assign sa  = a_i[3:2] ^ a_i[1:0];
        assign q_o = {sa[1] ^ sa[0], sa, a_i[3] ^ a_i[2], a_i[3:2], a_i[1] ^ a_i[0], a_i[1:0]};
    end else if (W == W_GF4) begin : g_w2
        assign q_o = {a_i[1] ^ a_i[0], a_i[1:0]};
    end else begin : g_bad_w
        $error("fac_expand: W must be 4 or 2");
    end

endmodule

// File: rtl/masked_fac_pipe.sv
// Pipelined share-wise factor-sum generator with valid/ready slices and flush.
// Optional input re-masking of shares 0/1 is enabled by MASKED_FAC_REFRESH_EN.
module masked_fac_pipe
    import masked_sbox_pkg::*;
#(
    parameter  int W      = 4,
    parameter  int SHARES = 2,
    parameter  int STAGES = 1,
    localparam int QW     = qw_of(W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SHARES*W-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SHARES*QW-1:0] out_data,
    output logic                 busy
`ifdef MASKED_FAC_REFRESH_EN
    ,
    input  logic [W-1:0]         rand_i
`endif
);

    localparam int DW = SHARES * QW;

    if (W != W_GF16 && W != W_GF4) begin : g_bad_w
        $error("masked_fac_pipe: W must be 4 or 2");
    end
    if (SHARES < 1 || SHARES > 4) begin : g_bad_shares
        $error("masked_fac_pipe: SHARES must be 1..4");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("masked_fac_pipe: STAGES must be 1..3");
    end

    logic [SHARES*W-1:0] shares_m;

`ifdef MASKED_FAC_REFRESH_EN
    if (SHARES < 2) begin : g_bad_refresh
        $error("masked_fac_pipe: refresh needs SHARES >= 2");
    end
    // Same mask on two shares keeps the unmasked XOR unchanged
    always_comb begin
        shares_m          = in_data;
        shares_m[0 +: W]  = in_data[0 +: W] ^ rand_i;
        shares_m[W +: W]  = in_data[W +: W] ^ rand_i;
    end
`else
    assign shares_m = in_data;
`endif

    logic [DW-1:0] exp_data;

    for (genvar s = 0; s < SHARES; s++) begin : g_exp
        fac_expand #(.W(W)) u_exp (
            .a_i (shares_m[s*W +: W]),
            .q_o (exp_data[s*QW +: QW])
        );
    end

    logic [STAGES-1:0] v_q, v_d;
    logic [DW-1:0]     d_q [STAGES];
    logic [DW-1:0]     d_d [STAGES];
    logic [STAGES:0]   cv;
    logic [DW-1:0]     cd  [STAGES+1];
    logic [STAGES-1:0] open;

    // Slice k can load when out_ready is high or any slice at/after k is empty
    for (genvar k = 0; k < STAGES; k++) begin : g_open
        localparam logic [STAGES-1:0] LOW = STAGES'((1 << k) - 1);
        assign open[k] = out_ready | ~&(v_q | LOW);
    end

    always_comb begin
        cv    = {v_q, in_valid};
        cd[0] = exp_data;
        for (int k = 0; k < STAGES; k++) begin
            cd[k+1] = d_q[k];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < STAGES; k++) begin
            if (flush) begin
                v_d[k] = 1'b0;
            end else if (open[k]) begin
                v_d[k] = cv[k];
                if (cv[k]) begin
                    d_d[k] = cd[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = open[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign busy      = |v_q;

endmodule
